ones_frame_accum: RTL
=====================

# ones_frame_accum

Downstream stage of the 7-bit ones-counter: consumes the registered 3-bit per-word count (0..7) and sums it over a frame of words. It emits one frame total per frame on a valid/ready output with a one-entry output buffer. A frame ends either after `FRAME_LEN` accepted words or early on `in_last`. The block also flags totals above a programmable threshold.

## Interface
Parameters:
- `FRAME_LEN`, 16: words per full frame; legal range is 1..255.
- `THRESH`, 56: `out_above` is set when the frame total is strictly greater than this value.
- `SUM_W`, local and derived: `$clog2(7*FRAME_LEN+1)`. This is 7 for the default parameters.
- `IDX_W`, local and derived: `$clog2(FRAME_LEN+1)`.

Ports:
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_count`  in  3  per-word ones count, 0..7.
- `in_valid`  in  1  `in_count` is valid this cycle.
- `in_last`  in  1  with `in_valid`, this word closes the frame early.
- `in_ready`  out  1  the block accepts a word this cycle.
- `out_sum`  out  SUM_W  frame total.
- `out_words`  out  IDX_W  number of words in the frame, 1..FRAME_LEN.
- `out_above`  out  1  `out_sum > THRESH`.
- `out_valid`  out  1  the output buffer holds a frame result.
- `out_ready`  in  1  the consumer takes the result this cycle.

## Operation
- Accept condition: `in_valid && in_ready`. Transfer condition: `out_valid && out_ready`.
- `in_ready = !rst && (!out_valid || out_ready)`. This is combinational, so a stalled output stalls all input.
- Internal state is an accumulator `acc` (SUM_W bits) plus a word index `idx` (IDX_W bits).
- Two states:
  - ACCUM: `out_valid=0`, or the buffer is being drained this cycle.
  - FULL: `out_valid=1` and `out_ready=0`. Input is held off in this state.
- On accept of a non-final word: `acc <= acc + in_count`, `idx <= idx + 1`.
- A word is final when `in_last` is set, or when `idx == FRAME_LEN-1`.
- On accept of a final word:
  - `out_sum <= acc + in_count`
  - `out_words <= idx + 1`
  - `out_above <= (acc + in_count) > THRESH`
  - `out_valid <= 1`
  - `acc <= 0`, `idx <= 0`
- Arithmetic is unsigned and zero-extended to SUM_W. Overflow is impossible by construction, because the maximum total is `7*FRAME_LEN`.
- On transfer with no final-word accept in the same cycle: `out_valid <= 0`.
- Transfer and final-word accept in the same cycle: the new result overwrites the buffer and `out_valid` stays 1. There are no bubbles.
- `in_last` is ignored when `in_valid=0`. `in_last` on the FRAME_LEN-th word is equivalent to a normal full frame.
- `in_count` is don't-care when it is not being accepted.
- `FRAME_LEN=1`: every accepted word is a frame.

## Timing
- Reset values: `out_sum=0`, `out_words=0`, `out_above=0`, `out_valid=0`, `acc=0`, `idx=0`. `in_ready=0` while `rst` is high and 1 in the first cycle after reset.
- Latency: the result is visible on the outputs one cycle after the final word is accepted.
- Throughput: one word per cycle sustained while `out_ready=1`. Back-to-back frames lose no cycle.
- Output stability: while `out_valid=1 && out_ready=0`, `out_sum`, `out_words` and `out_above` hold stable.
- Reset mid-frame or mid-hold: the partial accumulation and any pending result are discarded. No output is produced for that frame.
- `out_ready` asserted while `out_valid=0` has no effect.

## Structure
- Shared package `ones_count_pkg` holds:
  - `CNT_W=3`
  - `MAX_PER_WORD=7`
  - a function `frame_sum_w(frame_len)` returning `$clog2(MAX_PER_WORD*frame_len+1)`; the ones-counter stage uses this package too.
- Single flat module; no sub-module is warranted.
- The datapath is the accumulator adder, the index counter, the threshold comparator and the output register.

## Test plan
- Full frame: `FRAME_LEN=4`, `THRESH=10`, counts 3,3,3,2 with `out_ready=1` → one cycle later `out_sum=11`, `out_words=4`, `out_above=1`, valid for one cycle.
- Early end: counts 7,7 with `in_last` on the second word → `out_sum=14`, `out_words=2`, `out_above=1`. The next frame starts from `acc=0`.
- Backpressure: hold `out_ready=0` after a frame completes → `in_ready=0` and outputs stable for 5 cycles. Raise `out_ready` → `in_ready=1` that same cycle, and a final word accepted in that cycle replaces the result with no gap.
- Maximum value: default parameters, 16 words of 7 → `out_sum=112`, `out_words=16`, `out_above=1`. Count 56 across a frame → `out_above=0`, since the compare is strict.
- Reset mid-frame: accept 2 words (5, 6), assert `rst` for one cycle, then send 4 words of 1 with `FRAME_LEN=4` → `out_sum=4`, `out_words=4`, and no output for the aborted frame.
- Gapped input: random `in_valid` gaps within a `FRAME_LEN=4` frame of 1,2,3,4 → `out_sum=10`, `out_words=4`. Gaps do not change `idx`.

Source files
------------

// File: rtl/ones_count_pkg.sv
// Shared definitions for the ones-counter stage and its downstream frame accumulator.
package ones_count_pkg;

  localparam int CNT_W        = 3;
  localparam int MAX_PER_WORD = 7;

  // Width needed to hold the largest possible frame total without overflow.
  function automatic int frame_sum_w(input int frame_len);
    return $clog2(MAX_PER_WORD * frame_len + 1);
  endfunction

endpackage

// File: rtl/ones_frame_accum.sv
// Sums per-word ones counts over a frame (FRAME_LEN words or early in_last) and
// presents the total through a one-entry valid/ready output buffer.
module ones_frame_accum
  import ones_count_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  parameter  int THRESH    = 56,
  localparam int SUM_W     = frame_sum_w(FRAME_LEN),
  localparam int IDX_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [IDX_W-1:0] out_words,
  output logic             out_above,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state;
  logic [SUM_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] sum_next;
  logic             accept;
  logic             transfer;
  logic             final_word;

  // The state is fully implied by the output handshake; FULL blocks all input.
  always_comb begin
    state = ACCUM;
    if (out_valid && !out_ready) state = FULL;
  end

  assign in_ready   = !rst && (state == ACCUM);
  assign accept     = in_valid && in_ready;
  assign transfer   = out_valid && out_ready;
  assign final_word = in_last || (idx == IDX_W'(FRAME_LEN - 1));
  assign sum_next   = acc + SUM_W'(in_count);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      out_sum   <= '0;
      out_words <= '0;
      out_above <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (transfer) out_valid <= 1'b0;
      if (accept) begin
        if (final_word) begin
          // A same-cycle transfer is overridden here, so frames never bubble.
          out_sum   <= sum_next;
          out_words <= idx + IDX_W'(1);
          out_above <= int'(sum_next) > THRESH;
          out_valid <= 1'b1;
          acc       <= '0;
          idx       <= '0;
        end else begin
          acc <= sum_next;
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule
